// File: rtl/id_ex_skid_buffer_pkg.sv
// Shared definitions for the ID->EX skid buffer: default sizes and state encoding.
package id_ex_skid_buffer_pkg;

    localparam int W_DEFAULT        = 32;
    localparam int N_FIELDS_DEFAULT = 17;
    localparam int STALL_W_DEFAULT  = 16;

    // Encoding 2'd3 is unused; the FSM treats it as illegal and recovers to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Number of bundles held in a given state.
    function automatic logic [1:0] occupancy_of(state_t s);
        case (s)
            BUSY:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_skid_buffer_field_reg.sv
// Wide enable-load register with synchronous clear, used for the main and skid entries.
module pipe_field_reg #(
    parameter int WIDTH = 544
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over load so reset leaves a known all-zero bundle.
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/id_ex_skid_buffer.sv
// ID->EX receiving register stage: two-entry skid buffer with registered
// in_ready/out_valid, synchronous flush and a saturating stall counter.
module id_ex_skid_buffer
    import id_ex_skid_buffer_pkg::*;
#(
    parameter int W        = W_DEFAULT,
    parameter int N_FIELDS = N_FIELDS_DEFAULT,
    parameter int STALL_W  = STALL_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_FIELDS*W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_FIELDS*W-1:0] out_data,
    output logic [1:0]            occupancy,
    output logic [STALL_W-1:0]    stall_cycles
);

    localparam int DW = N_FIELDS * W;

    state_t          state;
    state_t          state_next;
    logic            acc;
    logic            drain;
    logic            load_main;
    logic            load_skid;
    logic            main_from_skid;
    logic [DW-1:0]   main_d;
    logic [DW-1:0]   main_q;
    logic [DW-1:0]   skid_q;

    assign acc   = in_valid && in_ready;
    assign drain = out_valid && out_ready;

    // Next-state and data-enable decode; flush overrides everything and suppresses loads.
    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_next = BUSY;
                    load_main  = 1'b1;
                end
            end
            BUSY: begin
                if (acc && drain) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_next     = BUSY;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        if (flush) begin
            state_next = EMPTY;
            load_main  = 1'b0;
            load_skid  = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    // State register with handshake/occupancy outputs registered from the next state,
    // so in_ready and out_valid never depend combinationally on any input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != FULL);
            out_valid <= (state_next != EMPTY);
            occupancy <= occupancy_of(state_next);
        end
    end

    // Saturating count of cycles where EX holds off a valid bundle; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (out_valid && !out_ready && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

    pipe_field_reg #(.WIDTH(DW)) u_main (
        .clk (clk),
        .clr (rst),
        .en  (load_main),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_field_reg #(.WIDTH(DW)) u_skid (
        .clk (clk),
        .clr (rst),
        .en  (load_skid),
        .d   (in_data),
        .q   (skid_q)
    );

    assign out_data = main_q;

endmodule
